// File: rtl/instr_fetch_unit.sv
// Instruction fetch: one request in flight, 2-entry {pc,instr} buffer to decode; response-to-if_valid is 1 cycle (0 with IFU_BYPASS_EN).
// Requests are held off while the buffer is full or a request is in flight; redirects flush the buffer and drop in-flight data.
module instr_fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_instr,
    input  logic            if_ready
);

    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_inflight_pc;
    logic            r_outstanding;
    logic            r_drop;
    logic            r_stale;
    logic [XLEN-1:0] r_fifo_pc    [0:1];
    logic [XLEN-1:0] r_fifo_instr [0:1];
    logic            r_rd_ptr;
    logic            r_wr_ptr;
    logic [1:0]      r_count;

    logic w_req_acc;
    logic w_rsp_own;
    logic w_rsp_live;
    logic w_bypass;
    logic w_fifo_nempty;
    logic w_pop;
    logic w_push;
    logic [1:0] w_unused_pc_lsb;

    assign w_unused_pc_lsb = redirect_pc[1:0];

    assign imem_req_valid = rst_n && !redirect_valid && !r_outstanding && (r_count < 2'd2);
    assign imem_req_addr  = r_fetch_pc;
    assign w_req_acc      = imem_req_valid && imem_req_ready;

    // r_stale marks a response still owed by a request that was cut off by reset
    assign w_rsp_own     = imem_rsp_valid && !r_stale;
    assign w_rsp_live    = w_rsp_own && !r_drop && !redirect_valid;
    assign w_fifo_nempty = (r_count != 2'd0);
`ifdef IFU_BYPASS_EN
    assign w_bypass = w_rsp_live && !w_fifo_nempty;
`else
    assign w_bypass = 1'b0;
`endif

    assign if_valid = rst_n && (w_fifo_nempty || w_bypass);
    assign w_pop    = rst_n && if_ready && w_fifo_nempty;
    assign w_push   = w_rsp_live && !(w_bypass && if_ready);

    always_comb begin
        if_pc    = '0;
        if_instr = '0;
        if (rst_n && w_fifo_nempty) begin
            if_pc    = r_fifo_pc[r_rd_ptr];
            if_instr = r_fifo_instr[r_rd_ptr];
        end
`ifdef IFU_BYPASS_EN
        else if (rst_n && w_bypass) begin
            if_pc    = r_inflight_pc;
            if_instr = imem_rsp_data;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fetch_pc    <= RESET_PC;
            r_outstanding <= 1'b0;
            r_drop        <= 1'b0;
            r_stale       <= (r_stale || r_outstanding) && !imem_rsp_valid;
            r_rd_ptr      <= 1'b0;
            r_wr_ptr      <= 1'b0;
            r_count       <= 2'd0;
        end else begin
            if (imem_rsp_valid)
                r_stale <= 1'b0;
            if (w_rsp_own)
                r_outstanding <= 1'b0;
            if (w_req_acc) begin
                r_outstanding <= 1'b1;
                r_inflight_pc <= r_fetch_pc;
                r_fetch_pc    <= r_fetch_pc + XLEN'(4);
            end
            if (redirect_valid) begin
                r_fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
                r_drop     <= r_outstanding && !w_rsp_own;
                r_rd_ptr   <= 1'b0;
                r_wr_ptr   <= 1'b0;
                r_count    <= 2'd0;
            end else begin
                if (w_rsp_own)
                    r_drop <= 1'b0;
                if (w_push) begin
                    r_fifo_pc[r_wr_ptr]    <= r_inflight_pc;
                    r_fifo_instr[r_wr_ptr] <= imem_rsp_data;
                    r_wr_ptr               <= ~r_wr_ptr;
                end
                if (w_pop)
                    r_rd_ptr <= ~r_rd_ptr;
                r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a latency-programmable memory model and an output scoreboard.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_ready;

    int total = 0;
    int bad   = 0;
    int lat   = 1;
    int cyc   = 0;

`ifdef IFU_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    logic [31:0] exp_q[$];

    instr_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .if_ready       (if_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            nxt();
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: %0d outputs missing, want 0", nm, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Memory: accepts at the sampled edge, answers lat cycles later with ~addr
    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready)
                mq.push_back('{imem_req_addr, cyc + lat});
            @(posedge clk);
            #1;
            if (mq.size() > 0 && mq[0].due <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = ~mq[0].addr;
                void'(mq.pop_front());
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = '0;
            end
        end
    end

    initial begin : monitor
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (if_valid && if_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out: got pc %h want no output", if_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_pc", if_pc, e);
                    chk("out_instr", if_instr, ~e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b1;
        if_ready       = 1'b1;
        repeat (3) nxt();
        @(negedge clk);
        chk1("rst_req_valid", imem_req_valid, 1'b0);
        chk1("rst_if_valid", if_valid, 1'b0);
        chk("rst_if_pc", if_pc, 32'h0);
        chk("rst_if_instr", if_instr, 32'h0);
        chk("rst_fetch_pc", imem_req_addr, 32'h0);

        // Streaming: requests every other cycle, outputs 0,4,8
        nxt();
        rst_n = 1'b1;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk1("p1_req_valid", imem_req_valid, (i % 2) == 0);
            if ((i % 2) == 0)
                chk("p1_req_addr", imem_req_addr, 32'(i * 2));
            nxt();
            if (i == 4)
                imem_req_ready = 1'b0;
        end
        drain("p1");

        // Decode stalled: buffer fills to exactly two entries
        nxt();
        if_ready       = 1'b0;
        imem_req_ready = 1'b1;
        repeat (9) nxt();
        @(negedge clk);
        chk1("p2_full_if_valid", if_valid, 1'b1);
        chk1("p2_full_req_valid", imem_req_valid, 1'b0);
        chk("p2_head_pc", if_pc, 32'hC);
        exp_q.push_back(32'hC);
        exp_q.push_back(32'h10);
        nxt();
        if_ready       = 1'b1;
        imem_req_ready = 1'b0;
        drain("p2");
        @(negedge clk);
        chk1("p2_only_two", if_valid, 1'b0);

        // Redirect with a full buffer: head still consumed, second entry flushed
        nxt();
        if_ready       = 1'b0;
        imem_req_ready = 1'b1;
        repeat (5) nxt();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        if_ready       = 1'b1;
        exp_q.push_back(32'h14);
        @(negedge clk);
        chk1("p3b_redir_noreq", imem_req_valid, 1'b0);
        nxt();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b0;
        @(negedge clk);
        chk1("p3b_flushed", if_valid, 1'b0);
        chk("p3b_redir_addr", imem_req_addr, 32'h200);
        drain("p3b");

        // Redirect while a request is outstanding: its response is dropped
        nxt();
        lat            = 3;
        imem_req_ready = 1'b1;
        nxt();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h103;
        @(negedge clk);
        chk1("p3_redir_noreq", imem_req_valid, 1'b0);
        nxt();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk1("p3_wait_req", imem_req_valid, 1'b0);
        chk1("p3_empty", if_valid, 1'b0);
        nxt();
        @(negedge clk);
        chk1("p3_dropped", if_valid, 1'b0);
        nxt();
        @(negedge clk);
        chk1("p3_req_valid", imem_req_valid, 1'b1);
        chk("p3_req_addr", imem_req_addr, 32'h100);
        exp_q.push_back(32'h100);
        nxt();
        imem_req_ready = 1'b0;
        lat            = 1;
        drain("p3");

        // Address wrap and response-to-output latency
        nxt();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        nxt();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0);
        @(negedge clk);
        chk("p4_req_top", imem_req_addr, 32'hFFFF_FFFC);
        nxt();
        @(negedge clk);
        chk1("p4_rsp_cycle_valid", if_valid, BYP);
        chk1("p4_rsp_cycle_noreq", imem_req_valid, 1'b0);
`ifdef IFU_BYPASS_EN
        chk("p4_byp_instr", if_instr, 32'h3);
`endif
        nxt();
        @(negedge clk);
        chk1("p4_next_cycle_valid", if_valid, !BYP);
        chk1("p4_wrap_req_valid", imem_req_valid, 1'b1);
        chk("p4_wrap_addr", imem_req_addr, 32'h0);
        nxt();
        imem_req_ready = 1'b0;
        drain("p4");

        // Reset with a request in flight: late response must not appear
        nxt();
        lat            = 3;
        imem_req_ready = 1'b1;
        nxt();
        rst_n = 1'b0;
        @(negedge clk);
        chk1("p5_rst_req_valid", imem_req_valid, 1'b0);
        chk1("p5_rst_if_valid", if_valid, 1'b0);
        nxt();
        rst_n = 1'b1;
        @(negedge clk);
        chk1("p5_first_req", imem_req_valid, 1'b1);
        chk("p5_first_addr", imem_req_addr, 32'h0);
        exp_q.push_back(32'h0);
        nxt();
        imem_req_ready = 1'b0;
        @(negedge clk);
        chk1("p5_stale_hidden", if_valid, 1'b0);
        nxt();
        @(negedge clk);
        chk1("p5_stale_not_queued", if_valid, 1'b0);
        drain("p5");
        lat = 1;
        repeat (4) nxt();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter XLEN, default 32: address and instruction width.
REQ-002 Parameter RESET_PC, default 32'h0: first fetch address after reset.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 redirect_valid  input  1  branch/jump redirect from the next-PC stage.
REQ-006 redirect_pc  input  XLEN  redirect target address.
REQ-007 imem_req_valid  output  1  instruction memory request valid.
REQ-008 imem_req_addr  output  XLEN  request address, equals the internal fetch PC.
REQ-009 imem_req_ready  input  1  memory accepts the request when high with imem_req_valid.
REQ-010 imem_rsp_valid  input  1  response valid; in order, at least 1 cycle after acceptance, never back-pressured.
REQ-011 imem_rsp_data  input  XLEN  fetched instruction word.
REQ-012 if_valid  output  1  fetched instruction available to decode.
REQ-013 if_pc  output  XLEN  address of the presented instruction.
REQ-014 if_instr  output  XLEN  presented instruction word.
REQ-015 if_ready  input  1  decode consumes when high with if_valid.

Function
REQ-016 Internal state: fetch_pc, 2-entry FIFO of {pc, instr}, outstanding flag (max 1 request in flight), drop flag, addr-in-flight register.
REQ-017 Request issue rule: imem_req_valid = !redirect_valid && !outstanding && (fifo_count < 2); the credit rule guarantees FIFO space for every response.
REQ-018 On request acceptance: outstanding set, in-flight addr = fetch_pc, fetch_pc += 4 modulo 2^XLEN (32'hFFFFFFFC wraps to 0).
REQ-019 On imem_rsp_valid: outstanding clears; if drop is clear, {in-flight addr, imem_rsp_data} is enqueued; if drop is set, the response is discarded and drop clears.
REQ-020 if_valid = FIFO non-empty; if_pc/if_instr show the head entry; dequeue on if_valid && if_ready.
REQ-021 Enqueue and dequeue in the same cycle leave fifo_count unchanged, with order preserved.
REQ-022 Redirect takes priority over everything: FIFO flushed, fetch_pc = redirect_pc, no request issued that cycle; an outstanding request sets drop; a response arriving in the redirect cycle is discarded.
REQ-023 redirect_pc[1:0] are ignored and forced to 0 when loaded into fetch_pc.
REQ-024 A dequeue in a redirect cycle is still a valid consumption of the old head; the flush follows it.
REQ-025 Minimum latency without bypass: response in cycle N produces if_valid in cycle N+1.

Reset
REQ-026 While rst_n is low: fetch_pc=RESET_PC, FIFO empty, outstanding=0, drop=0, imem_req_valid=0, if_valid=0, if_pc=0, if_instr=0.
REQ-027 The first request (addr RESET_PC) is issued in the first cycle with rst_n high.
REQ-028 Reset during an outstanding request discards that request's late response, which is never enqueued.

Configuration
REQ-029 Macro IFU_BYPASS_EN defined: when the FIFO is empty and a non-dropped response arrives with no redirect, if_valid asserts in the same cycle with the response pc/instr; if if_ready is also high, the entry is not enqueued.
REQ-030 IFU_BYPASS_EN undefined: no combinational path from imem_rsp_* to if_*; latency per REQ-025.

Verification
REQ-031 Reset release, imem_req_ready=1, 1-cycle response, if_ready=1 -> requests at 0x0,0x4,0x8 every 2 cycles; if_pc sequence 0x0,0x4,0x8.
REQ-032 if_ready=0 for 10 cycles -> exactly 2 entries buffered, imem_req_valid low, no loss; release gives in-order output.
REQ-033 Redirect to 0x103 while a request is outstanding -> next request addr 0x100; the in-flight response is dropped; the FIFO is empty the next cycle.
REQ-034 fetch_pc=0xFFFFFFFC accepted -> next request addr 0x00000000.
REQ-035 With IFU_BYPASS_EN, empty FIFO, response in cycle N -> if_valid in cycle N, if_instr equals imem_rsp_data; without it -> cycle N+1.
REQ-036 rst_n low mid-request, response arrives after release -> response not output; the first output is from RESET_PC.
